coord_source_mux: RTL

Parametrised successor to the fixed two-way keyboard/ultrasonic arm-control selection. Accepts NUM_SRC independent (x,y) coordinate sources, each with a valid strobe. The active source is stepped by two operator switches. Drives one slew-rate-limited (x,y) target to the inverse-kinematics/servo path, and returns the arm to a home pose when the active source goes silent.

---
 rtl/coord_source_mux.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/coord_source_mux.sv
// coord_source_mux
//   Selects one of NUM_SRC (x,y) coordinate sources with two operator switches.
//   It drives a slew-rate-limited target to the arm IK/servo path. When the
//   active source stops sending valid samples, the target returns to a home pose.
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   next_src, prev_src   switch levels; a rising edge steps the active source up or down
//   src_x, src_y         packed per-source coordinates; source i is at [i*COORD_W +: COORD_W]
//   src_valid            per-source sample strobes
//   out_x, out_y         slewed target (registered)
//   active_src           selected source (registered)
//   state                0=WAIT, 1=TRACK, 2=STALE (registered)
//   at_target            high when out equals the current target
//   stale                high in STALE
module coord_source_mux #(
  parameter int NUM_SRC       = 4,
  parameter int COORD_W       = 8,
  parameter int STEP          = 1,
  parameter int TICK_DIV      = 100000,
  parameter int TIMEOUT_TICKS = 50,
  parameter int HOME_X        = 4,
  parameter int HOME_Y        = 4,
  parameter int DEFAULT_SRC   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       next_src,
  input  logic                       prev_src,
  input  logic [NUM_SRC*COORD_W-1:0] src_x,
  input  logic [NUM_SRC*COORD_W-1:0] src_y,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [COORD_W-1:0]         out_x,
  output logic [COORD_W-1:0]         out_y,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic [1:0]                 state,
  output logic                       at_target,
  output logic                       stale
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [COORD_W:0]   STEP_W = (COORD_W+1)'(STEP);
  localparam logic [COORD_W-1:0] HX     = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] HY     = COORD_W'(HOME_Y);

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_TRACK = 2'd1, S_STALE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] tgt_x, tgt_y, tgt_x_d, tgt_y_d, out_x_d, out_y_d;
  logic [SW-1:0]      active_d;
  logic [TW-1:0]      tick_cnt, tick_cnt_d;
  logic [CW-1:0]      to_cnt, to_cnt_d;
  logic               next_q, prev_q;
  logic               tick, rise_next, rise_prev, src_chg, sel_valid;
  logic [COORD_W-1:0] sx [NUM_SRC];
  logic [COORD_W-1:0] sy [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign sx[i] = src_x[i*COORD_W +: COORD_W];
    assign sy[i] = src_y[i*COORD_W +: COORD_W];
  end

  // Move at most STEP toward tgt. The COORD_W+1 math keeps the difference
  // from wrapping, and snapping to tgt prevents overshoot.
  function automatic logic [COORD_W-1:0] slew(input logic [COORD_W-1:0] cur,
                                               input logic [COORD_W-1:0] tgt);
    logic [COORD_W:0] c, t, s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t >= c) s = ((t - c) <= STEP_W) ? t : c + STEP_W;
    else        s = ((c - t) <= STEP_W) ? t : c - STEP_W;
    return s[COORD_W-1:0];
  endfunction

  always_comb begin
    tick      = (tick_cnt == TW'(TICK_DIV - 1));
    rise_next = next_src & ~next_q;
    rise_prev = prev_src & ~prev_q;
    src_chg   = rise_next ^ rise_prev;   // both edges at once cancel
    sel_valid = src_valid[active_src] & ~src_chg;

    state_d    = state_q;
    tgt_x_d    = tgt_x;
    tgt_y_d    = tgt_y;
    active_d   = active_src;
    to_cnt_d   = to_cnt;
    tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
    // The slew step uses the registered tgt, so a sample arriving on the
    // same cycle as a tick only takes effect on the following tick.
    out_x_d    = tick ? slew(out_x, tgt_x) : out_x;
    out_y_d    = tick ? slew(out_y, tgt_y) : out_y;

    if (rise_next && !rise_prev)
      active_d = (active_src == SW'(NUM_SRC - 1)) ? '0 : active_src + SW'(1);
    else if (rise_prev && !rise_next)
      active_d = (active_src == '0) ? SW'(NUM_SRC - 1) : active_src - SW'(1);

    if (src_chg) begin
      state_d  = S_WAIT;
      to_cnt_d = '0;
    end else if (sel_valid) begin
      state_d  = S_TRACK;
      to_cnt_d = '0;
      tgt_x_d  = sx[active_src];
      tgt_y_d  = sy[active_src];
    end else if (state_q != S_STALE && tick) begin
      if (to_cnt == CW'(TIMEOUT_TICKS - 1)) begin
        state_d  = S_STALE;
        to_cnt_d = CW'(TIMEOUT_TICKS);   // held while stale
        tgt_x_d  = HX;
        tgt_y_d  = HY;
      end else begin
        to_cnt_d = to_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // Edge registers also load during reset, so a switch held through
    // reset does not produce an edge.
    next_q <= next_src;
    prev_q <= prev_src;
    if (!reset) begin
      state_q    <= S_WAIT;
      out_x      <= HX;
      out_y      <= HY;
      tgt_x      <= HX;
      tgt_y      <= HY;
      active_src <= SW'(DEFAULT_SRC);
      tick_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      state_q    <= state_d;
      out_x      <= out_x_d;
      out_y      <= out_y_d;
      tgt_x      <= tgt_x_d;
      tgt_y      <= tgt_y_d;
      active_src <= active_d;
      tick_cnt   <= tick_cnt_d;
      to_cnt     <= to_cnt_d;
    end
  end

  assign state     = state_q;
  assign at_target = (out_x == tgt_x) && (out_y == tgt_y);
  assign stale     = (state_q == S_STALE);
endmodule
